// File: rtl/sram_arb_rr.sv
// Round-robin N-master arbiter for the asynchronous board SRAM, with wait states and read-to-write turnaround.
// Optional fixed-priority mode (extra input prio_mode) is built when SRAM_ARB_FIXED_PRIO_EN is defined.
module sram_arb_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
`ifdef SRAM_ARB_FIXED_PRIO_EN
  input  logic                                 prio_mode,
`endif
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_address,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]               m_read,
  input  logic [NUM_MASTERS-1:0]               m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_writedata,
  output logic [NUM_MASTERS-1:0]               m_waitrequest,
  output logic [DATA_WIDTH-1:0]                m_readdata,
  output logic [NUM_MASTERS-1:0]               m_readdataready,
  output logic [NUM_MASTERS-1:0]               grant,
  output logic                                 busy,
  output logic [ADDR_WIDTH-1:0]                sram_address,
  inout  wire  [DATA_WIDTH-1:0]                sram_data,
  output logic                                 sram_ce_n,
  output logic                                 sram_oe_n,
  output logic                                 sram_we_n,
  output logic [DATA_WIDTH/8-1:0]              sram_be_n
);
  // Handshake: a master holds its command until m_waitrequest[i] is low for one cycle; that cycle is the acceptance.
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_TURN   = 2'd2;

  logic [1:0]             r_state;
  logic [3:0]             r_cnt;
  logic [IW-1:0]          r_last;
  logic                   r_is_write;
  logic                   r_prev_read;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BE_WIDTH-1:0]    r_be_n;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_readdata;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_rdr;
  logic                   r_ce_n;
  logic                   r_oe_n;
  logic                   r_we_n;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_any;
  logic                   w_prio;
  logic                   w_done;
  logic [IW-1:0]          w_win;
  logic                   w_win_wr;
  logic [NUM_MASTERS-1:0] w_onehot;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [BE_WIDTH-1:0]    w_be;
  logic [DATA_WIDTH-1:0]  w_wdata;

  assign w_req = m_read | m_write;
  assign w_any = |w_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign w_prio = prio_mode;
`else
  assign w_prio = 1'b0;
`endif

  // Loops run farthest-first so the nearest requester overwrites the winner last.
  always_comb begin
    int j;
    j     = 0;
    w_win = r_last;
    if (w_prio) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (w_req[IW'(i)]) w_win = IW'(i);
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        j = int'(r_last) + k;
        if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
        if (w_req[IW'(j)]) w_win = IW'(j);
      end
    end
  end

  always_comb begin
    w_addr   = '0;
    w_be     = '0;
    w_wdata  = '0;
    w_win_wr = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win == IW'(i)) begin
        w_addr      = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_be        = m_byteenable[i*BE_WIDTH +: BE_WIDTH];
        w_wdata     = m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        w_win_wr    = m_write[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A reset arriving in the final access cycle abandons the access, so it also suppresses acceptance.
  assign w_done = (r_state == ST_ACCESS) && (r_cnt == 4'd0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= IW'(NUM_MASTERS - 1);
      r_is_write  <= 1'b0;
      r_prev_read <= 1'b0;
      r_addr      <= '0;
      r_be_n      <= '1;
      r_wdata     <= '0;
      r_readdata  <= '0;
      r_grant     <= '0;
      r_rdr       <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      r_rdr <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_last     <= w_win;
            r_grant    <= w_onehot;
            r_addr     <= w_addr;
            r_be_n     <= ~w_be;
            r_wdata    <= w_wdata;
            r_is_write <= w_win_wr;
            r_cnt      <= 4'(WAIT_CYCLES);
            if (w_win_wr && r_prev_read) begin
              r_state <= ST_TURN;
            end else begin
              r_state <= ST_ACCESS;
              r_ce_n  <= 1'b0;
              r_oe_n  <= w_win_wr;
              r_we_n  <= ~w_win_wr;
            end
          end
        end
        ST_TURN: begin
          r_state <= ST_ACCESS;
          r_ce_n  <= 1'b0;
          r_we_n  <= 1'b0;
        end
        ST_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_is_write) begin
              r_readdata <= sram_data;
              r_rdr      <= r_grant;
            end
            r_prev_read <= !r_is_write;
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= '1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_waitrequest   = w_done ? ~r_grant : {NUM_MASTERS{1'b1}};
  assign m_readdata      = r_readdata;
  assign m_readdataready = r_rdr;
  assign grant           = r_grant;
  assign busy            = (r_state != ST_IDLE);
  assign sram_address    = r_addr;
  assign sram_ce_n       = r_ce_n;
  assign sram_oe_n       = r_oe_n;
  assign sram_we_n       = r_we_n;
  assign sram_be_n       = r_be_n;
  assign sram_data       = (r_state == ST_ACCESS && r_is_write && !reset) ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_arb_rr.sv
// Bench for sram_arb_rr: SRAM model, per-master transaction lists, and a transaction-level timing/data reference.
// Directed scenarios first, then randomized traffic; fixed-priority scenario only when SRAM_ARB_FIXED_PRIO_EN is defined.
module tb_sram_arb_rr;
  localparam int NM = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int W  = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic prio_mode = 1'b0;
  logic [NM*AW-1:0] m_address;
  logic [NM*BW-1:0] m_byteenable;
  logic [NM-1:0]    m_read, m_write;
  logic [NM*DW-1:0] m_writedata;
  logic [NM-1:0]    m_waitrequest, m_readdataready, grant;
  logic [DW-1:0]    m_readdata;
  logic             busy;
  logic [AW-1:0]    sram_address;
  wire  [DW-1:0]    sram_data;
  logic             sram_ce_n, sram_oe_n, sram_we_n;
  logic [BW-1:0]    sram_be_n;

  always #5 clock = ~clock;

  sram_arb_rr #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
`ifdef SRAM_ARB_FIXED_PRIO_EN
    .prio_mode(prio_mode),
`endif
    .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdataready(m_readdataready), .grant(grant), .busy(busy), .sram_address(sram_address),
    .sram_data(sram_data), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  // Asynchronous SRAM model: 256 words aliased on the low address bits.
  logic [DW-1:0] sram_mem [256];
  logic          fill_mem = 1'b1;
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_address[7:0]] : {DW{1'bz}};
  always @(posedge clock) begin
    if (reset && fill_mem) begin
      for (int a = 0; a < 256; a++) sram_mem[a] <= DW'(a * 257) ^ 16'h5A3C;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < BW; b++)
        if (!sram_be_n[b]) sram_mem[sram_address[7:0]][b*8 +: 8] <= sram_data[b*8 +: 8];
    end
  end

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } tx_t;

  tx_t txs [NM][16];
  int  n_tx [NM];
  int  idx [NM];
  int  gap [NM];
  bit  acc_flag [NM];
  int  gap_max;

  // Reference state: the one access in flight, RR pointer, memory image and expected read data.
  bit            sched, s_wr, last_rd;
  int            s_m, s_start, s_acc, lr, rd_pulse_at, rd_m;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [BW-1:0] s_be;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_rdata, last_pulse_data;
  logic [NM-1:0] prev_dgrant;
  int            dut_glog [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NM-1:0] onehot(input int m);
    return NM'(1) << m;
  endfunction

  function automatic int pick(input logic [NM-1:0] req, input int last, input logic prio);
    if (prio) begin
      for (int i = 0; i < NM; i++) if (req[i]) return i;
    end
    for (int k = 1; k <= NM; k++) if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  task automatic clear_inputs();
    m_address = '0; m_byteenable = '0; m_read = '0; m_write = '0; m_writedata = '0;
  endtask

  task automatic do_reset();
    logic [2:0] ctl;
    @(posedge clock); #1;
    reset = 1'b1;
    clear_inputs();
    @(posedge clock); #1;
    @(negedge clock);
    ctl = {sram_ce_n, sram_oe_n, sram_we_n};
    chk("rst_ctl", ctl, 3'b111);
    chk("rst_be_n", sram_be_n, {BW{1'b1}});
    chk("rst_addr", sram_address, 0);
    chk("rst_wait", m_waitrequest, {NM{1'b1}});
    chk("rst_rdr", m_readdataready, 0);
    chk("rst_rdata", m_readdata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic set_tx(input int m, input int k, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    txs[m][k] = '{rd: rd, wr: wr, addr: a, data: d, be: be};
    if (n_tx[m] < k + 1) n_tx[m] = k + 1;
  endtask

  task automatic drive();
    logic [NM-1:0] rd, wr;
    rd = '0; wr = '0;
    for (int i = 0; i < NM; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        idx[i]++;
        gap[i] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      end
      if (gap[i] > 0) gap[i]--;
      else if (idx[i] < n_tx[i]) begin
        rd[i] = txs[i][idx[i]].rd;
        wr[i] = txs[i][idx[i]].wr;
        m_address[i*AW +: AW]    = txs[i][idx[i]].addr;
        m_byteenable[i*BW +: BW] = txs[i][idx[i]].be;
        m_writedata[i*DW +: DW]  = txs[i][idx[i]].data;
      end
    end
    m_read = rd;
    m_write = wr;
  endtask

  task automatic sample(input int t);
    bit            in_win, in_acc, acc_now;
    logic [NM-1:0] e_grant, e_wait, e_rdr, req;
    logic [BW-1:0] e_be_n;
    int            w, gi;
    in_win  = sched && t >= s_start && t <= s_acc;
    in_acc  = in_win && t >= s_acc - W;
    acc_now = sched && t == s_acc;
    e_grant = in_win ? onehot(s_m) : '0;
    e_wait  = acc_now ? ~onehot(s_m) : '1;
    chk("grant", grant, e_grant);
    chk("busy", busy, in_win);
    chk("waitrequest", m_waitrequest, e_wait);
    chk("ce_n", sram_ce_n, !in_acc);
    chk("oe_n", sram_oe_n, !(in_acc && !s_wr));
    chk("we_n", sram_we_n, !(in_acc && s_wr));
    chk("oe_we_excl", sram_oe_n | sram_we_n, 1);
    if (in_acc) begin
      e_be_n = ~s_be;
      chk("sram_address", sram_address, s_addr);
      chk("sram_be_n", sram_be_n, e_be_n);
      if (s_wr) chk("sram_wdata", sram_data, s_data);
    end
    if (t == rd_pulse_at) begin
      exp_rdata = exp_q.pop_front();
      e_rdr = onehot(rd_m);
      last_pulse_data = m_readdata;
    end else begin
      e_rdr = '0;
    end
    chk("readdataready", m_readdataready, e_rdr);
    chk("readdata", m_readdata, exp_rdata);
    if (grant != '0 && prev_dgrant == '0) begin
      gi = -1;
      for (int i = 0; i < NM; i++) if (grant[i]) gi = i;
      dut_glog.push_back(gi);
    end
    prev_dgrant = grant;
    if (acc_now) begin
      acc_flag[s_m] = 1'b1;
      if (s_wr) begin
        for (int b = 0; b < BW; b++) if (s_be[b]) ref_mem[s_addr[7:0]][b*8 +: 8] = s_data[b*8 +: 8];
        last_rd = 1'b0;
      end else begin
        exp_q.push_back(ref_mem[s_addr[7:0]]);
        rd_pulse_at = t + 1;
        rd_m = s_m;
        last_rd = 1'b1;
      end
    end
    req = m_read | m_write;
    if ((!sched || t > s_acc) && req != '0) begin
      w = pick(req, lr, prio_mode);
      s_m = w;
      s_wr = txs[w][idx[w]].wr;
      s_addr = txs[w][idx[w]].addr;
      s_data = txs[w][idx[w]].data;
      s_be = txs[w][idx[w]].be;
      s_start = t + 1;
      s_acc = t + 1 + W + ((s_wr && last_rd) ? 1 : 0);
      lr = w;
      sched = 1'b1;
    end
  endtask

  task automatic run_engine(input int budget);
    bit all_done;
    int t;
    sched = 1'b0; lr = NM - 1; last_rd = 1'b0; rd_pulse_at = -1;
    exp_rdata = '0; exp_q.delete(); prev_dgrant = '0; dut_glog.delete();
    for (int i = 0; i < NM; i++) begin idx[i] = 0; gap[i] = 0; acc_flag[i] = 1'b0; end
    all_done = 1'b0;
    t = 0;
    while (t < budget) begin
      drive();
      @(negedge clock);
      sample(t);
      all_done = 1'b1;
      for (int i = 0; i < NM; i++) if (idx[i] + int'(acc_flag[i]) < n_tx[i]) all_done = 1'b0;
      if (all_done && (!sched || t > s_acc) && t >= rd_pulse_at) break;
      @(posedge clock); #1;
      t++;
    end
    chk("engine_done", all_done, 1);
    @(posedge clock); #1;
    clear_inputs();
  endtask

  task automatic new_scenario();
    for (int i = 0; i < NM; i++) n_tx[i] = 0;
    gap_max = 0;
    do_reset();
  endtask

  task automatic chk_glog(input string tag, input int k, input int exp);
    chk(tag, (k < dut_glog.size()) ? dut_glog[k] : -1, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] ctl;
    int kind;
    for (int a = 0; a < 256; a++) ref_mem[a] = DW'(a * 257) ^ 16'h5A3C;
    clear_inputs();
    for (int i = 0; i < NM; i++) n_tx[i] = 0;
    do_reset();
    fill_mem = 1'b0;

    // Write 0xBEEF then read it back from master 0.
    new_scenario();
    set_tx(0, 0, 1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    set_tx(0, 1, 1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11);
    run_engine(200);
    chk("s1_readback", last_pulse_data, 16'hBEEF);

    // All four masters reading continuously: grant order 0,1,2,3,0,1.
    new_scenario();
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < 2; k++) set_tx(m, k, 1'b1, 1'b0, AW'(m * 16 + k), 16'h0, 2'b11);
    run_engine(400);
    for (int k = 0; k < 6; k++) chk_glog("s2_order", k, k % NM);

    // Master 1 read and master 2 write pending together: read, turnaround, write.
    new_scenario();
    set_tx(1, 0, 1'b1, 1'b0, 20'h00021, 16'h0, 2'b11);
    set_tx(2, 0, 1'b0, 1'b1, 20'h00022, 16'hA5C3, 2'b11);
    run_engine(200);
    chk_glog("s3_first", 0, 1);
    chk_glog("s3_second", 1, 2);

    // Master 3 with read and write both high: a byte-lane-0 write.
    new_scenario();
    set_tx(3, 0, 1'b1, 1'b1, 20'h00033, 16'h1234, 2'b01);
    set_tx(3, 1, 1'b1, 1'b0, 20'h00033, 16'h0000, 2'b11);
    run_engine(200);
    chk("s4_merge", last_pulse_data, {ref_mem[8'h33][15:8], 8'h34});

    // Reset in the final access cycle of a read from master 2.
    new_scenario();
    m_read[2] = 1'b1;
    m_address[2*AW +: AW] = 20'h00044;
    m_byteenable[2*BW +: BW] = 2'b11;
    @(posedge clock); #1;
    repeat (W) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(negedge clock);
    chk("abort_wait", m_waitrequest, {NM{1'b1}});
    @(posedge clock); #1;
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    ctl = {sram_ce_n, sram_oe_n, sram_we_n};
    chk("abort_ctl", ctl, 3'b111);
    chk("abort_grant", grant, 0);
    chk("abort_wait2", m_waitrequest, {NM{1'b1}});
    chk("abort_rdr", m_readdataready, 0);
    chk("abort_busy", busy, 0);
    @(posedge clock); #1;
    m_read = '1;
    @(negedge clock);
    chk("abort_rdr2", m_readdataready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_first_winner", grant, 4'b0001);
    @(posedge clock); #1;
    clear_inputs();

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: master 0 always beats master 2.
    new_scenario();
    prio_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_tx(0, k, 1'b1, 1'b0, AW'(k), 16'h0, 2'b11);
      set_tx(2, k, 1'b1, 1'b0, AW'(k + 8), 16'h0, 2'b11);
    end
    run_engine(400);
    for (int k = 0; k < 4; k++) chk_glog("prio_order", k, 0);
    chk_glog("prio_then_2", 4, 2);
    prio_mode = 1'b0;
`endif

    // Randomized traffic from all masters with random gaps.
    for (int rep = 0; rep < 3; rep++) begin
      new_scenario();
      gap_max = 3;
      for (int m = 0; m < NM; m++) begin
        for (int k = 0; k < 8; k++) begin
          kind = int'($urandom_range(0, 2));
          set_tx(m, k, kind != 1, kind != 0,
                 {4'($urandom_range(0, 15)), 12'h000, 4'($urandom_range(0, 15))},
                 DW'($urandom), BW'($urandom_range(0, 3)));
        end
      end
      run_engine(3000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
